// File: rtl/cpu_pkg.sv
// Shared definitions for the sequenced 8-bit CPU: widths, instruction field
// positions, opcode map and the sequencer state encoding.
package cpu_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int ADDR_BITS   = 5;
  localparam int PC_BITS     = 5;
  localparam int INSTR_WIDTH = 20;

  localparam int OPC_MSB  = 19;
  localparam int OPC_LSB  = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 11;
  localparam int RSVD_MSB = 10;
  localparam int RSVD_LSB = 8;
  localparam int OFF_MSB  = 7;
  localparam int OFF_LSB  = 0;

  localparam logic [3:0] OP_ALU_MAX = 4'h9;
  localparam logic [3:0] OP_LDI     = 4'hA;
  localparam logic [3:0] OP_RSVD    = 4'hB;
  localparam logic [3:0] OP_JMP     = 4'hC;
  localparam logic [3:0] OP_BZ      = 4'hD;
  localparam logic [3:0] OP_NOP     = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Signal bundle between the sequencer, the instruction memory and the
// ALU/data-memory datapath; master is the sequencer side.
interface cpu_sequencer_if;

  // Fetch handshake: instr_req is held high (with pc stable) until a cycle in
  // which instr_valid is also high; that cycle transfers the instruction.
  // instr_valid while instr_req is low carries no meaning and is ignored.
  logic                                 start;
  logic                                 instr_req;
  logic [cpu_pkg::PC_BITS-1:0]          pc;
  logic                                 instr_valid;
  logic [cpu_pkg::INSTR_WIDTH-1:0]      instruction;

  logic [3:0]                           opcode_o;
  logic [cpu_pkg::ADDR_BITS-1:0]        addr_o;
  logic [cpu_pkg::DATA_WIDTH-1:0]       offset_o;
  logic                                 sel1_o;
  logic                                 sel3_o;
  logic                                 wen_o;
  logic                                 zero_i;

  logic                                 busy;
  logic                                 halted;
  logic                                 illegal;
  cpu_pkg::state_t                      dbg_state;

  modport master (
    input  start, instr_valid, instruction, zero_i,
    output instr_req, pc, opcode_o, addr_o, offset_o, sel1_o, sel3_o, wen_o,
           busy, halted, illegal, dbg_state
  );

  modport slave (
    output start, instr_valid, instruction, zero_i,
    input  instr_req, pc, opcode_o, addr_o, offset_o, sel1_o, sel3_o, wen_o,
           busy, halted, illegal, dbg_state
  );

endinterface

// File: rtl/cpu_decode.sv
// Combinational opcode classifier; NOP and the reserved opcode share the
// "advance pc" path, so no separate NOP flag is produced.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_alu_o,
  output logic       is_ldi_o,
  output logic       is_jmp_o,
  output logic       is_bz_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  always_comb begin
    is_alu_o     = (opcode_i <= OP_ALU_MAX);
    is_ldi_o     = (opcode_i == OP_LDI);
    is_jmp_o     = (opcode_i == OP_JMP);
    is_bz_o      = (opcode_i == OP_BZ);
    is_halt_o    = (opcode_i == OP_HALT);
    is_illegal_o = (opcode_i == OP_RSVD);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetches over a request/valid handshake and
// walks the datapath through decode, memory read, execute and write-back.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  cpu_sequencer_if.master bus
);

  localparam logic [PC_BITS-1:0] PC_ONE = 1;

  state_t                  state_q, state_d;
  logic [PC_BITS-1:0]      pc_q, pc_d;
  logic                    zero_q, zero_d;
  logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
  logic                    armed_q;

  logic                    is_alu, is_ldi, is_jmp, is_bz, is_halt, is_illegal;
  logic                    start_ok;
  logic [PC_BITS-1:0]      pc_inc;
  logic [PC_BITS-1:0]      offset_pc;
  logic                    rsvd_unused;

  cpu_decode u_decode (
    .opcode_i     (opcode_of(ir_q)),
    .is_alu_o     (is_alu),
    .is_ldi_o     (is_ldi),
    .is_jmp_o     (is_jmp),
    .is_bz_o      (is_bz),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal)
  );

  // armed_q keeps a start that coincides with reset release from launching.
  assign start_ok    = bus.start & armed_q;
  assign pc_inc      = pc_q + PC_ONE;
  assign offset_pc   = ir_q[OFF_LSB +: PC_BITS];
  assign rsvd_unused = ^ir_q[RSVD_MSB:RSVD_LSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      zero_q  <= 1'b0;
      ir_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zero_q  <= zero_d;
      ir_q    <= ir_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    zero_d  = zero_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_ok) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          zero_d  = 1'b0;
        end
      end
      ST_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instruction;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_alu) begin
          state_d = ST_MEM_RD;
        end else if (is_ldi) begin
          state_d = ST_WB;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else if (is_jmp) begin
          pc_d    = offset_pc;
          state_d = ST_FETCH;
        end else if (is_bz) begin
          pc_d    = zero_q ? offset_pc : pc_inc;
          state_d = ST_FETCH;
        end else begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      ST_MEM_RD: state_d = ST_EXEC;
      ST_EXEC: begin
        zero_d  = bus.zero_i;
        state_d = ST_WB;
      end
      ST_WB: begin
        pc_d    = pc_inc;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset clears them,
  // wen_o included, without waiting for a clock edge.
  always_comb begin
    bus.instr_req = (state_q == ST_FETCH);
    bus.pc        = pc_q;
    bus.opcode_o  = opcode_of(ir_q);
    bus.addr_o    = ir_q[ADDR_MSB:ADDR_LSB];
    bus.offset_o  = ir_q[OFF_MSB:OFF_LSB];
    bus.sel1_o    = (state_q == ST_EXEC) | ((state_q == ST_WB) & is_alu);
    bus.sel3_o    = (state_q == ST_WB) & is_ldi;
    bus.wen_o     = (state_q == ST_WB);
    bus.busy      = (state_q != ST_IDLE) & (state_q != ST_HALT);
    bus.halted    = (state_q == ST_HALT);
    bus.illegal   = (state_q == ST_DECODE) & is_illegal;
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a program table stepped through the fetch
// handshake, a write-back scoreboard, and hand sequences for start/reset.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int SB_W = ADDR_BITS + DATA_WIDTH + 1 + 4;

  typedef struct {
    logic [INSTR_WIDTH-1:0] instr;
    int                     delay;
    logic                   zero;
    logic [PC_BITS-1:0]     exp_pc;
    int                     exp_len;
    int                     exp_wen;
    int                     exp_ill;
    logic                   exp_halt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [SB_W-1:0] exp_q[$];
  vec_t vecs[14];

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("fetch_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},     bus.instr_req, 0);
    check({tag, "_wen"},     bus.wen_o, 0);
    check({tag, "_illegal"}, bus.illegal, 0);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_halted"},  bus.halted, 0);
    check({tag, "_pc"},      bus.pc, 0);
    check({tag, "_opcode"},  bus.opcode_o, 0);
    check({tag, "_addr"},    bus.addr_o, 0);
    check({tag, "_offset"},  bus.offset_o, 0);
    check({tag, "_sel1"},    bus.sel1_o, 0);
    check({tag, "_sel3"},    bus.sel3_o, 0);
  endtask

  task automatic sb_on_wen();
    logic [SB_W-1:0] act;
    logic [SB_W-1:0] exp;
    act = {bus.addr_o, bus.offset_o, bus.sel3_o, bus.opcode_o};
    if (exp_q.size() == 0) begin
      check("sb_unexpected_wen", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check("wb_fields", 32'(act), 32'(exp));
    end
  endtask

  // Entered at a negedge; leaves at the negedge where the next fetch (or HALT/IDLE) shows.
  task automatic run_instr(input vec_t v);
    bit ok;
    int len;
    int wens;
    int ills;
    wait_fetch(ok);
    if (!ok) return;
    check("fetch_pc", bus.pc, v.exp_pc);
    for (int d = 0; d < v.delay; d++) begin
      bus.instr_valid = 1'b0;
      bus.start       = 1'b1;
      @(negedge clk);
      check("req_hold", bus.instr_req, 1);
      check("pc_hold", bus.pc, v.exp_pc);
    end
    bus.start       = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instruction = v.instr;
    bus.zero_i      = v.zero;
    if (v.exp_wen != 0)
      exp_q.push_back({v.instr[ADDR_MSB:ADDR_LSB], v.instr[OFF_MSB:OFF_LSB],
                       (v.instr[OPC_MSB:OPC_LSB] == OP_LDI), v.instr[OPC_MSB:OPC_LSB]});
    @(negedge clk);
    bus.instruction = ~v.instr;
    len  = 0;
    wens = 0;
    ills = 0;
    for (int c = 0; c < 8; c++) begin
      if (!bus.busy || bus.instr_req) break;
      if (len == 2 && v.exp_len == 4) begin
        check("exec_sel1", bus.sel1_o, 1);
        check("exec_opcode", bus.opcode_o, v.instr[OPC_MSB:OPC_LSB]);
      end
      if (bus.wen_o) begin
        wens++;
        sb_on_wen();
      end
      if (bus.illegal) ills++;
      len++;
      @(negedge clk);
    end
    check("cycles", len, v.exp_len);
    check("wen_count", wens, v.exp_wen);
    check("illegal_count", ills, v.exp_ill);
    check("halted", bus.halted, v.exp_halt);
  endtask

  initial begin
    bit ok;
    int n;

    //          instr     dly zero pc     len wen ill halt
    vecs[0]  = '{20'hA082A, 0, 1'b0, 5'd0,  2, 1, 0, 1'b0}; // LDI addr1 0x2A
    vecs[1]  = '{20'h31005, 3, 1'b0, 5'd1,  4, 1, 0, 1'b0}; // ALU 3, late valid
    vecs[2]  = '{20'h11800, 0, 1'b1, 5'd2,  4, 1, 0, 1'b0}; // ALU sets zero
    vecs[3]  = '{20'hD0010, 0, 1'b0, 5'd3,  1, 0, 0, 1'b0}; // BZ taken
    vecs[4]  = '{20'h9F8FF, 0, 1'b0, 5'd16, 4, 1, 0, 1'b0}; // ALU clears zero
    vecs[5]  = '{20'hD0005, 0, 1'b1, 5'd17, 1, 0, 0, 1'b0}; // BZ not taken
    vecs[6]  = '{20'hA0000, 1, 1'b0, 5'd18, 2, 1, 0, 1'b0}; // LDI 0
    vecs[7]  = '{20'hB1234, 0, 1'b0, 5'd19, 1, 0, 1, 1'b0}; // reserved
    vecs[8]  = '{20'hC00FF, 0, 1'b0, 5'd20, 1, 0, 0, 1'b0}; // JMP 31
    vecs[9]  = '{20'hE0000, 0, 1'b0, 5'd31, 1, 0, 0, 1'b0}; // NOP wraps
    vecs[10] = '{20'h02011, 0, 1'b1, 5'd0,  4, 1, 0, 1'b0}; // ALU sets zero
    vecs[11] = '{20'hA1077, 0, 1'b0, 5'd1,  2, 1, 0, 1'b0}; // LDI keeps zero
    vecs[12] = '{20'hD0007, 0, 1'b0, 5'd2,  1, 0, 0, 1'b0}; // BZ taken
    vecs[13] = '{20'hF0000, 0, 1'b0, 5'd7,  1, 0, 0, 1'b1}; // HALT

    bus.start       = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.zero_i      = 1'b0;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_state", bus.dbg_state, ST_IDLE);

    // Junk valid while idle, and start coinciding with reset release.
    bus.instr_valid = 1'b1;
    bus.instruction = 20'hFFFFF;
    rst       = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rel_start_busy", bus.busy, 0);
    check("rel_start_req", bus.instr_req, 0);
    @(negedge clk);
    check("idle_valid_opcode", bus.opcode_o, 0);

    do_start();
    check("start_req", bus.instr_req, 1);
    check("start_pc", bus.pc, 0);

    for (int i = 0; i < 14; i++) run_instr(vecs[i]);

    bus.instr_valid = 1'b0;
    @(negedge clk);
    check("halt_busy", bus.busy, 0);
    check("halt_halted", bus.halted, 1);
    check("halt_pc", bus.pc, 7);
    check("halt_req", bus.instr_req, 0);

    // Restart clears pc and the zero flag: BZ at 0 must fall through.
    do_start();
    check("restart_req", bus.instr_req, 1);
    check("restart_pc", bus.pc, 0);
    check("restart_halted", bus.halted, 0);
    run_instr('{20'hD0009, 0, 1'b0, 5'd0, 1, 0, 0, 1'b0});

    // ALU op at pc 1, reset asserted mid-WB.
    wait_fetch(ok);
    check("rst_seq_pc", bus.pc, 1);
    bus.instr_valid = 1'b1;
    bus.instruction = 20'h5503C;
    bus.zero_i      = 1'b0;
    exp_q.push_back({5'd10, 8'h3C, 1'b0, 4'h5});
    @(negedge clk);
    bus.instr_valid = 1'b0;
    n = 0;
    while (!bus.wen_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("rst_seq_reach_wb", bus.wen_o, 1);
    if (bus.wen_o) sb_on_wen();
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("midwb_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_req", bus.instr_req, 0);
    do_start();
    check("post_rst_start_req", bus.instr_req, 1);
    check("post_rst_start_pc", bus.pc, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
